pipe_adder: RTL and testbench



---
 rtl/pipe_adder_pkg.sv | 13 +
 rtl/adder_chunk.sv | 14 +
 rtl/pipe_adder.sv | 111 +++++++++++
 tb/tb_pipe_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared stage payload type and stage-count helper for pipe_adder (flags via PIPE_ADDER_FLAGS_EN)
package pipe_adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int stages_f(input int width, input int chunk);
        return (width / chunk < 1) ? 1 : width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit adder with carry in/out, one per pipeline stage
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, ci_i};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined adder/subtractor, one CHUNK slice per stage; ovf/zero ports built only with PIPE_ADDER_FLAGS_EN
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout
`ifdef PIPE_ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int STAGES = stages_f(WIDTH, CHUNK);

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign bx       = sub ? ~b : b;
    assign c0       = sub | cin;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // The A word is consumed from the bottom while sums rotate in at the top,
    // so after the last stage it holds z in order. B' shrinks by one slice per stage.
    genvar s;
    generate
        for (s = 0; s < STAGES; s++) begin : g
            localparam int BW = WIDTH - s * CHUNK;
            logic [WIDTH-1:0] sa, a_d, a_q;
            logic [BW-1:0]    sb;
            logic             sc, sv, co;
            logic [CHUNK-1:0] sum;
            stage_ctl_t       ctl_d, ctl_q;
            if (s == 0) begin : g_src
                assign sa = a;
                assign sb = bx;
                assign sc = c0;
                assign sv = in_valid;
            end else begin : g_src
                assign sa = g[s-1].a_q;
                assign sb = g[s-1].g_b.b_q;
                assign sc = g[s-1].ctl_q.carry;
                assign sv = g[s-1].ctl_q.valid;
            end
            adder_chunk #(.CHUNK(CHUNK)) u_add (
                .a_i (sa[CHUNK-1:0]),
                .b_i (sb[CHUNK-1:0]),
                .ci_i(sc),
                .s_o (sum),
                .co_o(co)
            );
            // Next stage word: drop the consumed slice, insert its sum at the top.
            always_comb begin
                a_d   = (sa >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
                ctl_d = '{valid: sv, carry: co};
            end
            // Stage register: cleared by reset, frozen with the whole pipe when the output stalls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctl_q <= '0;
                    a_q   <= '0;
                end else if (adv) begin
                    ctl_q <= ctl_d;
                    a_q   <= a_d;
                end
            end
            if (s < STAGES - 1) begin : g_b
                logic [BW-CHUNK-1:0] b_q;
                // Unconsumed B' slices only matter next to a valid bit, so no reset.
                always_ff @(posedge clk) begin
                    if (adv) b_q <= sb[BW-1:CHUNK];
                end
            end
`ifdef PIPE_ADDER_FLAGS_EN
            if (s == STAGES - 1) begin : g_ovf
                logic ovf_d, ovf_q;
                assign ovf_d = (sa[CHUNK-1] == sb[CHUNK-1]) && (sum[CHUNK-1] != sa[CHUNK-1]);
                // Overflow is decided where the operand MSB slice is consumed.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) ovf_q <= 1'b0;
                    else if (adv) ovf_q <= ovf_d;
                end
            end
`endif
        end
    endgenerate

    assign out_valid = g[STAGES-1].ctl_q.valid;
    assign z         = g[STAGES-1].a_q;
    assign cout      = g[STAGES-1].ctl_q.carry;
`ifdef PIPE_ADDER_FLAGS_EN
    assign ovf       = g[STAGES-1].g_ovf.ovf_q;
    assign zero      = out_valid && (z == '0);
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized and directed self-checking bench for pipe_adder (flags checked with PIPE_ADDER_FLAGS_EN)
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [31:0] a, b, z;
`ifdef PIPE_ADDER_FLAGS_EN
    logic        ovf, zero, o_ovf, o_zero;
`endif

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .cout(cout)
`ifdef PIPE_ADDER_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    typedef struct {
        logic [31:0] z;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        q[$];
    exp_t        ex;
    int          total = 0, passes = 0;
    logic        got, ex_ok, o_valid, o_rdy, o_cout;
    logic [31:0] o_z;

    // Reference: plain integer arithmetic; overflow means the signed result does not fit in 32 bits.
    function automatic exp_t model(input logic [31:0] x, y, input logic ci, sb);
        exp_t            e;
        longint          r;
        longint unsigned u;
        if (sb) begin
            e.z = x - y;
            e.c = (x >= y);
            r   = longint'($signed(x)) - longint'($signed(y));
        end else begin
            u   = longint'(x) + longint'(y) + longint'(ci);
            e.z = u[31:0];
            e.c = u[32];
            r   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        e.o = (r != longint'($signed(e.z)));
        return e;
    endfunction

    task automatic cycle(input logic v, input logic [31:0] x, y, input logic ci, sb, rd);
        @(negedge clk);
        in_valid = v; a = x; b = y; cin = ci; sub = sb; out_ready = rd;
        #1;
        o_valid = out_valid; o_rdy = in_ready; o_z = z; o_cout = cout;
`ifdef PIPE_ADDER_FLAGS_EN
        o_ovf = ovf; o_zero = zero;
`endif
        got   = out_valid && out_ready;
        ex_ok = got && q.size() > 0;
        if (ex_ok) ex = q.pop_front();
        if (v && in_ready) q.push_back(model(x, y, ci, sb));
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || z !== 32'h0 || cout !== 1'b0)
            $display("FAIL reset_state: valid=%b z=%h cout=%b, expected 0 0 0", out_valid, z, cout);
        else passes++;
`ifdef PIPE_ADDER_FLAGS_EN
        total++;
        if (ovf !== 1'b0 || zero !== 1'b0) $display("FAIL reset_flags: ovf=%b zero=%b, expected 0 0", ovf, zero);
        else passes++;
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, expected 1", in_ready);
        else passes++;
    endtask

    task automatic test_directed();
        logic [31:0] da[4] = '{32'hFFFFFFFF, 32'h00FFFFFF, 32'd5, 32'd7};
        logic [31:0] db[4] = '{32'd1, 32'd0, 32'd7, 32'd5};
        logic        dc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        ds[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ez[4] = '{32'h0, 32'h01000000, 32'hFFFFFFFE, 32'd2};
        logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          lat;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, da[k], db[k], dc[k], ds[k], 1'b1);
            total++;
            if (o_rdy !== 1'b1) $display("FAIL directed_ready[%0d]: in_ready=%b, expected 1", k, o_rdy);
            else passes++;
            lat = 0;
            for (int i = 1; i <= 8 && lat == 0; i++) begin
                cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
                if (got) lat = i;
            end
            total++;
            if (lat != 4) $display("FAIL directed_latency[%0d]: latency=%0d, expected 4", k, lat);
            else passes++;
            total++;
            if (o_z !== ez[k] || o_cout !== ec[k])
                $display("FAIL directed_value[%0d]: z=%h cout=%b, expected z=%h cout=%b", k, o_z, o_cout, ez[k], ec[k]);
            else passes++;
`ifdef PIPE_ADDER_FLAGS_EN
            total++;
            if (o_ovf !== 1'b0 || o_zero !== (k == 0))
                $display("FAIL directed_flags[%0d]: ovf=%b zero=%b, expected ovf=0 zero=%b", k, o_ovf, o_zero, k == 0);
            else passes++;
`endif
        end
    endtask

    task automatic test_back_to_back();
        int n = 0, first = -1, last = -1;
        logic v;
        logic [31:0] x, y;
        for (int i = 0; i < 20; i++) begin
            v = (i < 8);
            x = (i == 2) ? 32'h7FFFFFFF : $urandom;
            y = (i == 2) ? 32'd1 : $urandom;
            cycle(v, x, y, (i == 2) ? 1'b0 : 1'($urandom_range(0, 1)), (i == 2) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b1);
            if (v) begin
                total++;
                if (o_rdy !== 1'b1) $display("FAIL b2b_ready[%0d]: in_ready=%b, expected 1", i, o_rdy);
                else passes++;
            end
            if (got) begin
                n++;
                if (first < 0) first = i;
                last = i;
                total++;
                if (!ex_ok || o_z !== ex.z || o_cout !== ex.c)
                    $display("FAIL b2b_value[%0d]: z=%h cout=%b, expected z=%h cout=%b", n, o_z, o_cout, ex.z, ex.c);
                else passes++;
`ifdef PIPE_ADDER_FLAGS_EN
                total++;
                if (o_ovf !== ex.o || o_zero !== (ex.z == 32'h0))
                    $display("FAIL b2b_flags[%0d]: ovf=%b zero=%b, expected ovf=%b zero=%b", n, o_ovf, o_zero, ex.o, ex.z == 32'h0);
                else passes++;
`endif
                if (n == 3) begin
                    total++;
                    if (o_z !== 32'h80000000) $display("FAIL b2b_ovf_case: z=%h, expected 80000000", o_z);
                    else passes++;
`ifdef PIPE_ADDER_FLAGS_EN
                    total++;
                    if (o_ovf !== 1'b1) $display("FAIL b2b_ovf_flag: ovf=%b, expected 1", o_ovf);
                    else passes++;
`endif
                end
            end
        end
        total++;
        if (n != 8 || last - first != 7)
            $display("FAIL b2b_rate: results=%0d span=%0d, expected 8 results over span 7", n, last - first);
        else passes++;
    endtask

    task automatic test_backpressure();
        logic [31:0] xa = $urandom, xb = $urandom;
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            total++;
            if (o_rdy !== 1'b1) $display("FAIL bp_fill_ready[%0d]: in_ready=%b, expected 1", i, o_rdy);
            else passes++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, xa, xb, 1'b1, 1'b0, 1'b0);
            total++;
            if (o_valid !== 1'b1 || o_rdy !== 1'b0 || q.size() != 4 || o_z !== q[0].z)
                $display("FAIL bp_stall[%0d]: valid=%b in_ready=%b queued=%0d z=%h, expected 1 0 4 z=%h",
                         i, o_valid, o_rdy, q.size(), o_z, (q.size() > 0) ? q[0].z : 32'hx);
            else passes++;
        end
        for (int i = 0; i < 12; i++) begin
            cycle(i == 0, xa, xb, 1'b1, 1'b0, 1'b1);
            if (i == 0) begin
                total++;
                if (o_rdy !== 1'b1 || got !== 1'b1)
                    $display("FAIL bp_release: in_ready=%b retire=%b, expected 1 1", o_rdy, got);
                else passes++;
            end
            if (got) begin
                n++;
                total++;
                if (!ex_ok || o_z !== ex.z || o_cout !== ex.c)
                    $display("FAIL bp_value[%0d]: z=%h cout=%b, expected z=%h cout=%b", n, o_z, o_cout, ex.z, ex.c);
                else passes++;
            end
        end
        total++;
        if (n != 5 || q.size() != 0) $display("FAIL bp_count: results=%0d left=%0d, expected 5 0", n, q.size());
        else passes++;
    endtask

    task automatic test_random();
        logic rd;
        for (int i = 0; i < 320; i++) begin
            rd = (i >= 300) || ($urandom_range(0, 3) != 0);
            cycle((i < 300) && ($urandom_range(0, 1) == 1), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
            total++;
            if (o_rdy !== (!o_valid || rd)) $display("FAIL rand_ready[%0d]: in_ready=%b, expected %b", i, o_rdy, !o_valid || rd);
            else passes++;
            if (got) begin
                total++;
                if (!ex_ok || o_z !== ex.z || o_cout !== ex.c)
                    $display("FAIL rand_value[%0d]: z=%h cout=%b, expected z=%h cout=%b", i, o_z, o_cout, ex.z, ex.c);
                else passes++;
`ifdef PIPE_ADDER_FLAGS_EN
                total++;
                if (o_ovf !== ex.o || o_zero !== (ex.z == 32'h0))
                    $display("FAIL rand_flags[%0d]: ovf=%b zero=%b, expected ovf=%b zero=%b", i, o_ovf, o_zero, ex.o, ex.z == 32'h0);
                else passes++;
`endif
            end
        end
        total++;
        if (q.size() != 0) $display("FAIL rand_drain: left=%0d, expected 0", q.size());
        else passes++;
    endtask

    task automatic test_reset_midflight();
        cycle(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) $display("FAIL rstmid_before: valid=%b, expected 1", out_valid);
        else passes++;
        #2 rst = 1'b1;
        #1;
        q.delete();
        total++;
        if (out_valid !== 1'b0 || z !== 32'h0 || cout !== 1'b0)
            $display("FAIL rstmid_async: valid=%b z=%h cout=%b, expected 0 0 0", out_valid, z, cout);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL rstmid_ready: in_ready=%b, expected 1", in_ready);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            total++;
            if (o_valid !== 1'b0) $display("FAIL rstmid_stale[%0d]: valid=%b, expected 0", i, o_valid);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
